// File: rtl/apb_regfile_slave.sv
// APB4 completer: NoRegs x DataWidth register bank with WaitCycles extra ACCESS cycles.
// Optional macro AXI_APB_REGFILE_PROT_CHECK_EN rejects unprivileged writes (pprot[0]=0).
package apb_regfile_pkg;
  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_req_t;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_resp_t;
endpackage

module apb_regfile_slave #(
  parameter int unsigned          NoRegs     = 16,
  parameter int unsigned          AddrWidth  = 32,
  parameter int unsigned          DataWidth  = 32,
  parameter logic [AddrWidth-1:0] BaseAddr   = '0,
  parameter int unsigned          WaitCycles = 0,
  parameter logic [DataWidth-1:0] RegRstVal  = '0,
  parameter type                  apb_req_t  = apb_regfile_pkg::apb_req_t,
  parameter type                  apb_resp_t = apb_regfile_pkg::apb_resp_t
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  apb_req_t                            apb_req_i,
  output apb_resp_t                           apb_resp_o,
  input  logic [NoRegs-1:0]                   reg_ro_i,
  input  logic [NoRegs-1:0][DataWidth-1:0]    reg_d_i,
  output logic [NoRegs-1:0][DataWidth-1:0]    reg_q_o
);
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned ByteOffW  = $clog2(StrbWidth);
  localparam int unsigned IdxW      = (NoRegs > 1) ? $clog2(NoRegs) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                           r_state, w_state_cur, w_state_nxt;
  logic [7:0]                       r_cnt, w_cnt_nxt;
  logic [AddrWidth-1:0]             w_off, w_idx;
  logic [IdxW-1:0]                  w_sel;
  logic                             w_dec_err, w_ro, w_prot_err;
  logic                             w_pready, w_slverr, w_do_write;
  logic [NoRegs-1:0][DataWidth-1:0] r_regs;

  // A SETUP phase is recognised in the same cycle the requester presents it, so a
  // transfer that closes with pready returns to IDLE and the next SETUP is seen at once.
  always_comb begin
    w_state_cur = r_state;
    if (r_state == IDLE && apb_req_i.psel && !apb_req_i.penable) w_state_cur = SETUP;
  end

  assign w_pready = (r_state == ACCESS) && apb_req_i.psel && apb_req_i.penable &&
                    (r_cnt == 8'(WaitCycles));

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    w_state_nxt = w_state_cur;
    w_cnt_nxt   = r_cnt;
    unique case (w_state_cur)
      IDLE:  w_state_nxt = IDLE;
      SETUP: begin
        w_state_nxt = ACCESS;
        w_cnt_nxt   = '0;
      end
      ACCESS: begin
        if (!apb_req_i.psel || w_pready) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_off     = apb_req_i.paddr - BaseAddr;
  assign w_idx     = w_off >> ByteOffW;
  assign w_dec_err = (apb_req_i.paddr < BaseAddr) || (w_idx >= AddrWidth'(NoRegs));
  assign w_sel     = w_idx[IdxW-1:0];
  assign w_ro      = reg_ro_i[w_sel];

`ifdef AXI_APB_REGFILE_PROT_CHECK_EN
  assign w_prot_err = apb_req_i.pwrite && !apb_req_i.pprot[0];
`else
  assign w_prot_err = 1'b0;
`endif

  assign w_slverr   = w_dec_err || (apb_req_i.pwrite && (w_ro || w_prot_err));
  assign w_do_write = w_pready && apb_req_i.pwrite && !w_slverr;

  // Response is all-zero outside the pready cycle, so no stale read data leaks.
  always_comb begin
    apb_resp_o = '0;
    if (w_pready) begin
      apb_resp_o.pready  = 1'b1;
      apb_resp_o.pslverr = w_slverr;
      if (!apb_req_i.pwrite && !w_dec_err)
        apb_resp_o.prdata = w_ro ? reg_d_i[w_sel] : r_regs[w_sel];
    end
  end

  // NOTE: the register bank is architectural state with a defined reset value, so it is reset
  // like any other flop rather than left to power-up contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_regs <= {NoRegs{RegRstVal}};
    end else if (w_do_write) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (apb_req_i.pstrb[b]) r_regs[w_sel][b*8 +: 8] <= apb_req_i.pwdata[b*8 +: 8];
      end
    end
  end

  assign reg_q_o = r_regs;

endmodule
